dfr_reservoir_sequencer: RTL and testbench
==========================================

// Module: dfr_reservoir_sequencer
// PURPOSE
// - Sequences the DFR reservoir: reads each input sample from input memory, drives it into the reservoir once per
//   virtual node, captures each node output and writes it to reservoir history memory at sample*VIRTUAL_NODES+node.
// - Sits between axi_cfg_regs (start/num_samples/status) and the reservoir + input/history memories in dfr_core_top.
// PARAMETERS
// - VIRTUAL_NODES                 10   virtual nodes per input sample (>=1)
// - RESERVOIR_DATA_WIDTH          32   sample / node data width
// - INPUT_ADDR_WIDTH              16   input memory address width
// - RESERVOIR_HISTORY_ADDR_WIDTH  20   history memory address width
// - TIMEOUT_CYCLES              1024   node-response watchdog limit (used only with DFR_SEQ_TIMEOUT_EN)
// PORTS
// - S_AXI_ACLK          in   1     clock
// - S_AXI_ARESET        in   1     synchronous, active-high reset
// - start               in   1     1-cycle pulse: begin run; ignored while busy
// - num_samples         in   INPUT_ADDR_WIDTH   samples to process, sampled on accepted start
// - busy                out  1     run in progress
// - done                out  1     sticky; set on run completion, cleared by next accepted start
// - error               out  1     sticky; watchdog or history overflow; cleared by next accepted start
// - in_mem_rd_en        out  1     input memory read strobe
// - in_mem_addr         out  INPUT_ADDR_WIDTH   input memory address (sample index)
// - in_mem_rd_data      in   RESERVOIR_DATA_WIDTH   read data, valid 1 cycle after in_mem_rd_en
// - res_en              out  1     1-cycle pulse: present res_data_in for node res_node_idx
// - res_node_idx        out  $clog2(VIRTUAL_NODES)  current virtual node (mask index)
// - res_data_in         out  RESERVOIR_DATA_WIDTH   current sample, held for whole sample
// - res_valid           in   1     reservoir node output valid (>=1 cycle after res_en)
// - res_data_out        in   RESERVOIR_DATA_WIDTH   node output, captured when res_valid
// - hist_wr_en          out  1     history write strobe
// - hist_addr           out  RESERVOIR_HISTORY_ADDR_WIDTH   history write address
// - hist_wr_data        out  RESERVOIR_DATA_WIDTH   history write data
// BEHAVIOUR
// - Reset: state IDLE; every output 0 (busy, done, error, strobes, addresses, data, res_node_idx).
// - FSM: IDLE -start-> FETCH (in_mem_rd_en=1, addr=sample) -> LOAD (latch rd_data into res_data_in)
//   -> DRIVE (res_en=1 for node) -> WAIT_NODE (until res_valid) -> WRITE (hist_wr_en=1, data=captured res_data_out)
//   -> node<VN-1 ? DRIVE (node+1) : sample<num_samples-1 ? FETCH (sample+1) : IDLE with done=1.
// - res_valid seen only in WAIT_NODE; asserted in any other state it is ignored.
// - Per node: 3 cycles minimum (DRIVE, WAIT_NODE with res_valid present, WRITE); per sample +2 (FETCH, LOAD).
// - hist_addr: counter from 0 at start, +1 after each WRITE; equals sample*VIRTUAL_NODES+node.
// - Overflow: WRITE at hist_addr = 2^RESERVOIR_HISTORY_ADDR_WIDTH-1 completes, then run ends: error=1, done=1.
// - num_samples==0: start -> IDLE next cycle with done=1, busy never asserted, no memory traffic.
// - start while busy: ignored, latched num_samples unchanged. start same cycle as done set: cannot occur (busy).
// - Reset mid-run: abort immediately, all outputs to reset values; no partial write completes after reset.
// - busy=1 from cycle after accepted start until cycle run ends (done set same cycle busy falls).
// CONFIGURATION
// - DFR_SEQ_TIMEOUT_EN defined: cycle counter in WAIT_NODE; reaching TIMEOUT_CYCLES without res_valid -> IDLE,
//   error=1, done=1, no history write for that node.
// - Not defined: WAIT_NODE waits indefinitely; error set only by history overflow; no counter logic.
// STRUCTURE
// - Package dfr_pkg: seq_state_t enum (IDLE,FETCH,LOAD,DRIVE,WAIT_NODE,WRITE), shared width constants.
// - Single module, no sub-modules; counters (sample, node, hist_addr, timeout) inline.
// TESTING
// - Reset mid-run at node 4 of sample 2 -> next cycle all outputs 0, state IDLE; new start runs from addr 0.
// - num_samples=3, VN=10, res_valid 1 cycle after res_en, in_mem[i]=i+1 -> 30 writes, hist_addr 0..29,
//   hist_wr_data == model(sample,node), done=1 after last write.
// - num_samples=0 start -> done=1 next cycle, busy never 1, no rd_en/res_en/hist_wr_en.
// - start pulsed while busy with num_samples=50 -> ignored, original run of 3 completes with 30 writes.
// - res_valid delayed 0..7 random cycles, spurious res_valid in DRIVE/WRITE -> exactly one write per node, correct data.
// - DFR_SEQ_TIMEOUT_EN, TIMEOUT_CYCLES=16, res_valid withheld at sample 1 node 0 -> error=1, done=1, 10 writes only.

Source files
------------

// File: rtl/dfr_pkg.sv
// Shared types and default sizes for the DFR reservoir sequencer.
package dfr_pkg;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    FETCH     = 3'd1,
    LOAD      = 3'd2,
    DRIVE     = 3'd3,
    WAIT_NODE = 3'd4,
    WRITE     = 3'd5
  } seq_state_t;

  localparam int unsigned DefVirtualNodes     = 10;
  localparam int unsigned DefDataWidth        = 32;
  localparam int unsigned DefInputAddrWidth   = 16;
  localparam int unsigned DefHistAddrWidth    = 20;
  localparam int unsigned DefTimeoutCycles    = 1024;

  // Index width that stays at least one bit wide when only one value exists.
  function automatic int unsigned idx_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/dfr_reservoir_sequencer.sv
// Steps each input sample through all virtual nodes and logs node outputs to history memory.
// Optional node-response watchdog enabled by defining DFR_SEQ_TIMEOUT_EN.
module dfr_reservoir_sequencer
  import dfr_pkg::*;
#(
  parameter int unsigned VIRTUAL_NODES                = DefVirtualNodes,
  parameter int unsigned RESERVOIR_DATA_WIDTH         = DefDataWidth,
  parameter int unsigned INPUT_ADDR_WIDTH             = DefInputAddrWidth,
  parameter int unsigned RESERVOIR_HISTORY_ADDR_WIDTH = DefHistAddrWidth,
  parameter int unsigned TIMEOUT_CYCLES               = DefTimeoutCycles,
  parameter int unsigned NodeIdxW                     = idx_width(VIRTUAL_NODES)
) (
  input  logic                                    S_AXI_ACLK,
  input  logic                                    S_AXI_ARESET,
  input  logic                                    start,
  input  logic [INPUT_ADDR_WIDTH-1:0]             num_samples,
  output logic                                    busy,
  output logic                                    done,
  output logic                                    error,
  output logic                                    in_mem_rd_en,
  output logic [INPUT_ADDR_WIDTH-1:0]             in_mem_addr,
  input  logic [RESERVOIR_DATA_WIDTH-1:0]         in_mem_rd_data,
  output logic                                    res_en,
  output logic [NodeIdxW-1:0]                     res_node_idx,
  output logic [RESERVOIR_DATA_WIDTH-1:0]         res_data_in,
  input  logic                                    res_valid,
  input  logic [RESERVOIR_DATA_WIDTH-1:0]         res_data_out,
  output logic                                    hist_wr_en,
  output logic [RESERVOIR_HISTORY_ADDR_WIDTH-1:0] hist_addr,
  output logic [RESERVOIR_DATA_WIDTH-1:0]         hist_wr_data
);

  localparam int unsigned Iaw = INPUT_ADDR_WIDTH;
  localparam int unsigned Haw = RESERVOIR_HISTORY_ADDR_WIDTH;
  localparam int unsigned Dw  = RESERVOIR_DATA_WIDTH;

  localparam logic [NodeIdxW-1:0] NodeOne   = NodeIdxW'(1);
  localparam logic [NodeIdxW-1:0] NodeLast  = NodeIdxW'(VIRTUAL_NODES - 1);
  localparam logic [Iaw-1:0]      SampleOne = Iaw'(1);
  localparam logic [Haw-1:0]      HistOne   = Haw'(1);

  if (VIRTUAL_NODES < 1 || TIMEOUT_CYCLES < 1) begin : g_param_check
    $error("VIRTUAL_NODES and TIMEOUT_CYCLES must both be at least 1");
  end

  seq_state_t          state_q, state_d;
  logic [Iaw-1:0]      sample_q, sample_d;
  logic [Iaw-1:0]      num_q, num_d;
  logic [NodeIdxW-1:0] node_q, node_d;
  logic [Haw-1:0]      hist_addr_q, hist_addr_d;
  logic [Dw-1:0]       sample_data_q, sample_data_d;
  logic [Dw-1:0]       node_out_q, node_out_d;
  logic                done_q, done_d;
  logic                error_q, error_d;

`ifdef DFR_SEQ_TIMEOUT_EN
  localparam int unsigned ToW = idx_width(TIMEOUT_CYCLES);
  localparam logic [ToW-1:0] ToOne  = ToW'(1);
  localparam logic [ToW-1:0] ToLast = ToW'(TIMEOUT_CYCLES - 1);

  logic [ToW-1:0] to_cnt_q, to_cnt_d;
  logic           to_hit;

  // Counts consecutive WAIT_NODE cycles without a node response.
  assign to_hit = (state_q == WAIT_NODE) && !res_valid && (to_cnt_q == ToLast);

  always_comb begin
    to_cnt_d = '0;
    if (state_q == WAIT_NODE && !res_valid && !to_hit) begin
      to_cnt_d = to_cnt_q + ToOne;
    end
  end

  always_ff @(posedge S_AXI_ACLK) begin
    if (S_AXI_ARESET) begin
      to_cnt_q <= '0;
    end else begin
      to_cnt_q <= to_cnt_d;
    end
  end
`else
  logic to_hit;
  assign to_hit = 1'b0;
`endif

  always_comb begin
    state_d       = state_q;
    sample_d      = sample_q;
    num_d         = num_q;
    node_d        = node_q;
    hist_addr_d   = hist_addr_q;
    sample_data_d = sample_data_q;
    node_out_d    = node_out_q;
    done_d        = done_q;
    error_d       = error_q;

    unique case (state_q)
      IDLE: begin
        if (start) begin
          num_d       = num_samples;
          sample_d    = '0;
          node_d      = '0;
          hist_addr_d = '0;
          error_d     = 1'b0;
          if (num_samples == '0) begin
            done_d = 1'b1;
          end else begin
            done_d  = 1'b0;
            state_d = FETCH;
          end
        end
      end
      FETCH: state_d = LOAD;
      LOAD: begin
        sample_data_d = in_mem_rd_data;
        state_d       = DRIVE;
      end
      DRIVE: state_d = WAIT_NODE;
      WAIT_NODE: begin
        if (res_valid) begin
          node_out_d = res_data_out;
          state_d    = WRITE;
        end else if (to_hit) begin
          state_d = IDLE;
          error_d = 1'b1;
          done_d  = 1'b1;
        end
      end
      WRITE: begin
        // The last history slot is still written; the run stops instead of wrapping.
        if (&hist_addr_q) begin
          state_d = IDLE;
          error_d = 1'b1;
          done_d  = 1'b1;
        end else begin
          hist_addr_d = hist_addr_q + HistOne;
          if (node_q != NodeLast) begin
            node_d  = node_q + NodeOne;
            state_d = DRIVE;
          end else if (sample_q + SampleOne != num_q) begin
            sample_d = sample_q + SampleOne;
            node_d   = '0;
            state_d  = FETCH;
          end else begin
            state_d = IDLE;
            done_d  = 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge S_AXI_ACLK) begin
    if (S_AXI_ARESET) begin
      state_q       <= IDLE;
      sample_q      <= '0;
      num_q         <= '0;
      node_q        <= '0;
      hist_addr_q   <= '0;
      sample_data_q <= '0;
      node_out_q    <= '0;
      done_q        <= 1'b0;
      error_q       <= 1'b0;
    end else begin
      state_q       <= state_d;
      sample_q      <= sample_d;
      num_q         <= num_d;
      node_q        <= node_d;
      hist_addr_q   <= hist_addr_d;
      sample_data_q <= sample_data_d;
      node_out_q    <= node_out_d;
      done_q        <= done_d;
      error_q       <= error_d;
    end
  end

  assign busy         = (state_q != IDLE);
  assign done         = done_q;
  assign error        = error_q;
  assign in_mem_rd_en = (state_q == FETCH);
  assign in_mem_addr  = sample_q;
  assign res_en       = (state_q == DRIVE);
  assign res_node_idx = node_q;
  assign res_data_in  = sample_data_q;
  assign hist_wr_en   = (state_q == WRITE);
  assign hist_addr    = hist_addr_q;
  assign hist_wr_data = node_out_q;

endmodule

// File: tb/tb_dfr_reservoir_sequencer.sv
// Randomized scoreboard bench for dfr_reservoir_sequencer; exercises the watchdog when
// DFR_SEQ_TIMEOUT_EN is defined.
module tb_dfr_reservoir_sequencer;

  localparam int unsigned VN  = 10;
  localparam int unsigned DW  = 32;
  localparam int unsigned IAW = 16;
  localparam int unsigned HAW = 6;
  localparam int unsigned TO  = 16;
  localparam int unsigned NIW = 4;

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic            start = 1'b0;
  logic [IAW-1:0]  num_samples = '0;
  logic            busy, done, error;
  logic            in_mem_rd_en;
  logic [IAW-1:0]  in_mem_addr;
  logic [DW-1:0]   in_mem_rd_data = '0;
  logic            res_en;
  logic [NIW-1:0]  res_node_idx;
  logic [DW-1:0]   res_data_in;
  logic            res_valid = 1'b0;
  logic [DW-1:0]   res_data_out = '0;
  logic            hist_wr_en;
  logic [HAW-1:0]  hist_addr;
  logic [DW-1:0]   hist_wr_data;

  always #5 clk = ~clk;

  dfr_reservoir_sequencer #(
    .VIRTUAL_NODES               (VN),
    .RESERVOIR_DATA_WIDTH        (DW),
    .INPUT_ADDR_WIDTH            (IAW),
    .RESERVOIR_HISTORY_ADDR_WIDTH(HAW),
    .TIMEOUT_CYCLES              (TO)
  ) dut (
    .S_AXI_ACLK    (clk),
    .S_AXI_ARESET  (rst),
    .start         (start),
    .num_samples   (num_samples),
    .busy          (busy),
    .done          (done),
    .error         (error),
    .in_mem_rd_en  (in_mem_rd_en),
    .in_mem_addr   (in_mem_addr),
    .in_mem_rd_data(in_mem_rd_data),
    .res_en        (res_en),
    .res_node_idx  (res_node_idx),
    .res_data_in   (res_data_in),
    .res_valid     (res_valid),
    .res_data_out  (res_data_out),
    .hist_wr_en    (hist_wr_en),
    .hist_addr     (hist_addr),
    .hist_wr_data  (hist_wr_data)
  );

  typedef struct {
    int unsigned  addr;
    logic [DW-1:0] data;
  } wr_t;

  wr_t           exp_q[$];
  logic [DW-1:0] mem[256];
  int            n_cmp = 0;
  int            n_fail = 0;
  int            traffic = 0;
  int            busy_seen = 0;
  int            writes = 0;
  int            res_en_cnt = 0;
  int            withhold_idx = -1;
  bit            rand_delay = 1'b0;
  bit            spurious = 1'b0;

  // Reservoir stand-in: a fixed mixing function of the presented sample and node index.
  function automatic logic [DW-1:0] node_fn(input logic [DW-1:0] x, input int unsigned k);
    return (x ^ (32'h9E37_79B9 * k)) + (k * 7 + 1);
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Input memory: data is valid only in the cycle after the read strobe.
  logic           rd_pend = 1'b0;
  logic [IAW-1:0] rd_addr = '0;
  always @(negedge clk) begin
    in_mem_rd_data = rd_pend ? mem[rd_addr[7:0]] : DW'($urandom);
    rd_pend = in_mem_rd_en;
    rd_addr = in_mem_addr;
  end

  // Reservoir responder with optional random latency and spurious valid pulses.
  bit            pend = 1'b0;
  int unsigned   pend_cnt = 0;
  logic [DW-1:0] resp_data = '0;
  always @(negedge clk) begin
    res_valid    = 1'b0;
    res_data_out = DW'($urandom);
    if (rst) begin
      pend = 1'b0;
    end else begin
      if (pend) begin
        if (pend_cnt == 0) begin
          res_valid    = 1'b1;
          res_data_out = resp_data;
          pend         = 1'b0;
        end else begin
          pend_cnt--;
        end
      end
      if (res_en) begin
        if (res_en_cnt != withhold_idx) begin
          pend      = 1'b1;
          pend_cnt  = rand_delay ? $urandom_range(0, 7) : 0;
          resp_data = node_fn(res_data_in, res_node_idx);
        end
        res_en_cnt++;
        if (spurious && $urandom_range(0, 1) == 1) res_valid = 1'b1;
      end
      if ((hist_wr_en || in_mem_rd_en) && spurious && $urandom_range(0, 1) == 1) begin
        res_valid = 1'b1;
      end
    end
  end

  // Monitor: every history write is matched against the scoreboard queue.
  always @(negedge clk) begin
    if (in_mem_rd_en || res_en || hist_wr_en) traffic++;
    if (busy) busy_seen++;
    if (hist_wr_en) begin
      if (exp_q.size() == 0) begin
        n_cmp++;
        n_fail++;
        $display("FAIL unexpected_write: addr %0d data 0x%0h, no write expected",
                 hist_addr, hist_wr_data);
      end else begin : pop_blk
        wr_t e;
        e = exp_q.pop_front();
        check("hist_addr", 64'(hist_addr), 64'(e.addr));
        check("hist_wr_data", 64'(hist_wr_data), 64'(e.data));
        writes++;
      end
    end
  end

  task automatic check_all_zero(input string name);
    check({name, ":busy"}, 64'(busy), 0);
    check({name, ":done"}, 64'(done), 0);
    check({name, ":error"}, 64'(error), 0);
    check({name, ":in_mem_rd_en"}, 64'(in_mem_rd_en), 0);
    check({name, ":in_mem_addr"}, 64'(in_mem_addr), 0);
    check({name, ":res_en"}, 64'(res_en), 0);
    check({name, ":res_node_idx"}, 64'(res_node_idx), 0);
    check({name, ":res_data_in"}, 64'(res_data_in), 0);
    check({name, ":hist_wr_en"}, 64'(hist_wr_en), 0);
    check({name, ":hist_addr"}, 64'(hist_addr), 0);
    check({name, ":hist_wr_data"}, 64'(hist_wr_data), 0);
  endtask

  // Expected writes: sample-major, node-minor, truncated at the end of history memory.
  task automatic queue_run(input int unsigned n);
    wr_t e;
    int unsigned cap = 1 << HAW;
    for (int unsigned w = 0; w < n * VN && w < cap; w++) begin
      e.addr = w;
      e.data = node_fn(mem[w / VN], w % VN);
      exp_q.push_back(e);
    end
  endtask

  task automatic pulse_start(input int unsigned n);
    num_samples = IAW'(n);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_idle(input string name);
    int c = 0;
    while (busy && c < 5000) begin
      @(negedge clk);
      c++;
    end
    check({name, ":idle_within_budget"}, 64'(busy), 0);
  endtask

  task automatic run(input string name, input int unsigned n);
    bit exp_err = (n * VN >= (1 << HAW));
    queue_run(n);
    res_en_cnt = 0;
    pulse_start(n);
    check({name, ":busy_after_start"}, 64'(busy), 64'(n != 0));
    check({name, ":done_after_start"}, 64'(done), 64'(n == 0));
    wait_idle(name);
    check({name, ":done"}, 64'(done), 1);
    check({name, ":error"}, 64'(error), 64'(exp_err));
    check({name, ":writes_left"}, 64'(exp_q.size()), 0);
  endtask

  task automatic fill_mem(input bit randomize_it);
    for (int i = 0; i < 256; i++) mem[i] = randomize_it ? DW'($urandom) : DW'(i + 1);
  endtask

  initial begin
    #500_000;
    $display("FAIL global_timeout: simulation still running, expected completion");
    $fatal(1, "global timeout");
  end

  initial begin
    int t0, b0, c;
    fill_mem(1'b0);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    check_all_zero("reset");
    rst = 1'b0;
    @(negedge clk);

    // Fixed one-cycle response latency, in_mem[i] = i+1.
    run("basic3", 3);

    // Zero-length run: done next cycle, no traffic, never busy.
    t0 = traffic;
    b0 = busy_seen;
    run("zero", 0);
    repeat (4) @(negedge clk);
    check("zero:traffic", 64'(traffic - t0), 0);
    check("zero:busy_seen", 64'(busy_seen - b0), 0);

    // Start while busy is ignored.
    queue_run(3);
    res_en_cnt = 0;
    pulse_start(3);
    repeat (5) @(negedge clk);
    pulse_start(50);
    wait_idle("busy_start");
    check("busy_start:done", 64'(done), 1);
    check("busy_start:writes_left", 64'(exp_q.size()), 0);
    t0 = traffic;
    repeat (5) @(negedge clk);
    check("busy_start:no_restart", 64'(traffic - t0), 0);

    // Random latency, spurious valids, random memory contents.
    rand_delay = 1'b1;
    spurious = 1'b1;
    for (int i = 0; i < 4; i++) begin
      fill_mem(1'b1);
      run("random", $urandom_range(1, 5));
    end

    // Reset at sample 2 node 4, then restart from address 0.
    writes = 0;
    queue_run(3);
    res_en_cnt = 0;
    pulse_start(3);
    c = 0;
    while (!(res_en && res_node_idx == 4 && writes == 24) && c < 5000) begin
      @(negedge clk);
      c++;
    end
    check("midreset:reached_node", 64'(c < 5000), 1);
    rst = 1'b1;
    @(negedge clk);
    check_all_zero("midreset");
    exp_q.delete();
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    run("after_reset", 2);

    // History overflow: 70 node writes requested into 64 slots.
    fill_mem(1'b1);
    run("overflow", 7);

`ifdef DFR_SEQ_TIMEOUT_EN
    // Withhold the response for sample 1 node 0.
    rand_delay = 1'b0;
    spurious = 1'b0;
    withhold_idx = 10;
    queue_run(1);
    res_en_cnt = 0;
    pulse_start(3);
    wait_idle("timeout");
    check("timeout:done", 64'(done), 1);
    check("timeout:error", 64'(error), 1);
    check("timeout:writes_left", 64'(exp_q.size()), 0);
    withhold_idx = -1;
    repeat (4) @(negedge clk);
`endif

    repeat (3) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
